// File: rtl/icache_fetch_port.sv
// Direct-mapped instruction cache, one 32-bit word per line, in front of the
// Fetcher. A miss refills the line with four byte reads over the arbitrated
// RAM port (little-endian), then answers the Fetcher with a one-cycle strobe.
module icache_fetch_port #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_result,
  output logic        mem_ready,
  input  logic        rob_clear,
  output logic        ram_req,
  input  logic        ram_gnt,
  output logic [31:0] ram_addr,
  input  logic [7:0]  ram_din
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } state_t;

  // Control and output registers
  state_t                  state_q,      state_d;
  logic [31:0]             base_q,       base_d;
  logic [2:0]              cnt_q,        cnt_d;
  logic                    pending_q,    pending_d;
  logic [31:0]             mem_result_q, mem_result_d;
  logic                    ram_req_q,    ram_req_d;
  logic [31:0]             ram_addr_q,   ram_addr_d;
  logic [LINES-1:0]        valid_q,      valid_d;

  // Line storage (tag/data carry no reset; valid bits gate their use)
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];

  logic                    fill_we;
  logic [31:0]             fill_data;

  logic [INDEX_BITS-1:0]   req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   base_idx;
  logic [TAG_W-1:0]        base_tag;
  logic                    hit;
  logic [1:0]              lane;
  logic                    unused_addr_bits;

  // Byte-offset bits of the fetch PC carry no information for word fetches.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign req_idx  = mem_addr[INDEX_BITS+1:2];
  assign req_tag  = mem_addr[31:INDEX_BITS+2];
  assign base_idx = base_q[INDEX_BITS+1:2];
  assign base_tag = base_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // ram_din lags ram_addr by one cycle, so READ cycle cnt stores byte cnt-1.
  assign lane      = cnt_q[1:0] - 2'd1;
  assign fill_data = {ram_din, mem_result_q[23:0]};

  // Replace one byte lane of a word.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  sel,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{sel, 3'b000} +: 8] = b;
    return w;
  endfunction

  // Next-state logic: everything freezes while rdy_in is low, except that a
  // flush still cancels an outstanding response.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    mem_result_d = mem_result_q;
    ram_req_d    = ram_req_q;
    ram_addr_d   = ram_addr_q;
    valid_d      = valid_q;
    fill_we      = 1'b0;

    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (mem_valid && !rob_clear) begin
            base_d    = {mem_addr[31:2], 2'b00};
            pending_d = 1'b1;
            if (hit) begin
              mem_result_d = data_q[req_idx];
              state_d      = RESP;
            end else begin
              ram_req_d = 1'b1;
              state_d   = REQ;
            end
          end
        end
        REQ: begin
          if (ram_gnt) begin
            state_d    = READ;
            cnt_d      = 3'd0;
            ram_addr_d = base_q;
          end
        end
        READ: begin
          if (cnt_q != 3'd0) begin
            mem_result_d = insert_byte(mem_result_q, lane, ram_din);
          end
          if (cnt_q < 3'd3) begin
            ram_addr_d = base_q + 32'(cnt_q) + 32'd1;
          end
          if (cnt_q == 3'd4) begin
            fill_we            = 1'b1;
            valid_d[base_idx]  = 1'b1;
            ram_req_d          = 1'b0;
            cnt_d              = 3'd0;
            state_d            = RESP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        RESP: begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // A flush during refill only drops the response; the refill still lands.
    if (rob_clear && ((state_q == REQ) || (state_q == READ))) begin
      pending_d = 1'b0;
    end
  end

  // Control/output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      mem_result_q <= '0;
      ram_req_q    <= 1'b0;
      ram_addr_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      mem_result_q <= mem_result_d;
      ram_req_q    <= ram_req_d;
      ram_addr_q   <= ram_addr_d;
      valid_q      <= valid_d;
    end
  end

  // Tag/data line write at the end of a refill.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_q[base_idx]  <= base_tag;
      data_q[base_idx] <= fill_data;
    end
  end

  assign mem_result = mem_result_q;
  assign ram_req    = ram_req_q;
  assign ram_addr   = ram_addr_q;
  assign mem_ready  = (state_q == RESP) & pending_q & ~rob_clear;

endmodule
